// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC register, byte-addressed instruction memory, instruction
// split into fields, valP computation and status classification, with a halt latch.
module fetch_stage #(
  parameter int          IMEM_BYTES = 1024,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_we,
  input  logic [63:0] pc_next,
  input  logic        imem_we,
  input  logic [63:0] imem_waddr,
  input  logic [7:0]  imem_wdata,
  output logic [63:0] pc,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [1:0]  stat,
  output logic        instr_valid,
  output logic [31:0] instr_count
);

  localparam int AW = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  logic [7:0]  mem_q [IMEM_BYTES];

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  stat_q, stat_d;

  logic [7:0]  b0, reg_byte;
  logic [3:0]  len;
  logic        has_reg, has_c9, has_c10, ifun_ok, adr;
  logic [64:0] end_addr;
  logic [63:0] c_base, valc_w;
  logic [1:0]  f_stat;

  // Memory is never reset so a loaded program survives a reset.
  always_ff @(posedge clk) begin
    if (imem_we && (imem_waddr < 64'(IMEM_BYTES)))
      mem_q[imem_waddr[AW-1:0]] <= imem_wdata;
  end

  function automatic logic [7:0] rd_byte(input logic [63:0] a);
    if (a < 64'(IMEM_BYTES)) return mem_q[a[AW-1:0]];
    else                     return 8'h00;
  endfunction

  always_comb begin
    b0      = rd_byte(pc_q);
    len     = 4'd1;
    has_reg = 1'b0;
    has_c9  = 1'b0;
    has_c10 = 1'b0;
    case (b0[7:4])
      4'h2, 4'h6, 4'hA, 4'hB: begin len = 4'd2;  has_reg = 1'b1; end
      4'h3, 4'h4, 4'h5:       begin len = 4'd10; has_reg = 1'b1; has_c10 = 1'b1; end
      4'h7, 4'h8:             begin len = 4'd9;  has_c9 = 1'b1; end
      default:                len = 4'd1;
    endcase
    case (b0[7:4])
      4'h2, 4'h7: ifun_ok = (b0[3:0] <= 4'd6);
      4'h6:       ifun_ok = (b0[3:0] <= 4'd3);
      default:    ifun_ok = (b0[3:0] == 4'd0);
    endcase
    // 65-bit sum so a PC near the top of the address space cannot wrap into range.
    end_addr = {1'b0, pc_q} + 65'(len) - 65'd1;
    adr      = (end_addr >= 65'(IMEM_BYTES));
    if (adr) begin
      len     = 4'd1;
      has_reg = 1'b0;
      has_c9  = 1'b0;
      has_c10 = 1'b0;
    end
    reg_byte = rd_byte(pc_q + 64'd1);
    c_base   = pc_q + (has_c10 ? 64'd2 : 64'd1);
    valc_w   = 64'd0;
    if (has_c9 || has_c10) begin
      for (int k = 0; k < 8; k++)
        valc_w[8*k +: 8] = rd_byte(c_base + 64'(k));
    end
    if (adr)                           f_stat = STAT_ADR;
    else if (b0[7:4] > 4'hB || !ifun_ok) f_stat = STAT_INS;
    else if (b0[7:4] == 4'h0)          f_stat = STAT_HLT;
    else                               f_stat = STAT_AOK;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    stat_d  = stat_q;
    if (state_q == RUN && pc_we) begin
      cnt_d = cnt_q + 32'd1;
      if (f_stat == STAT_AOK) begin
        pc_d = pc_next;
      end else begin
        state_d = HALTED;
        stat_d  = f_stat;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= 32'd0;
      stat_q  <= STAT_AOK;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      stat_q  <= stat_d;
    end
  end

  assign pc          = pc_q;
  assign icode       = b0[7:4];
  assign ifun        = b0[3:0];
  assign rA          = has_reg ? reg_byte[7:4] : 4'hF;
  assign rB          = has_reg ? reg_byte[3:0] : 4'hF;
  assign valC        = valc_w;
  assign valP        = pc_q + 64'(len);
  assign stat        = (state_q == HALTED) ? stat_q : f_stat;
  assign instr_valid = (state_q == RUN);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: table of single-instruction decodes at pc 0, then
// hand-written sequences for commit, halt latching, reset and address limits.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_we = 1'b0;
  logic [63:0] pc_next = 64'd0;
  logic        imem_we = 1'b0;
  logic [63:0] imem_waddr = 64'd0;
  logic [7:0]  imem_wdata = 8'd0;
  logic [63:0] pc, valC, valP;
  logic [3:0]  icode, ifun, rA, rB;
  logic [1:0]  stat;
  logic        instr_valid;
  logic [31:0] instr_count;

  int n_total = 0;
  int n_pass  = 0;

  fetch_stage #(.IMEM_BYTES(1024), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst), .pc_we(pc_we), .pc_next(pc_next),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .pc(pc), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
    .valP(valP), .stat(stat), .instr_valid(instr_valid), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] bytes;  // byte k at [8k+:8]
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic [1:0]  stat;
    bit          full;   // 0: only icode and stat are checked
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wr(input logic [63:0] a, input logic [7:0] d);
    @(negedge clk);
    imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
    @(posedge clk); #1;
    imem_we = 1'b0;
  endtask

  task automatic commit(input logic [63:0] nxt);
    @(negedge clk);
    pc_we = 1'b1; pc_next = nxt;
    @(posedge clk); #1;
    pc_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0]  = '{80'h0AF430,           4'h3, 4'h0, 4'hF, 4'h4, 64'd10,  64'd10, 2'd0, 1'b1};
    vecs[1]  = '{80'h2360,             4'h6, 4'h0, 4'h2, 4'h3, 64'd0,   64'd2,  2'd0, 1'b1};
    vecs[2]  = '{80'h66,               4'h6, 4'h6, 4'h0, 4'h0, 64'd0,   64'd0,  2'd3, 1'b0};
    vecs[3]  = '{80'h27,               4'h2, 4'h7, 4'h0, 4'h0, 64'd0,   64'd0,  2'd3, 1'b0};
    vecs[4]  = '{80'hC0,               4'hC, 4'h0, 4'h0, 4'h0, 64'd0,   64'd0,  2'd3, 1'b0};
    vecs[5]  = '{80'h01,               4'h0, 4'h1, 4'h0, 4'h0, 64'd0,   64'd0,  2'd3, 1'b0};
    vecs[6]  = '{80'h00,               4'h0, 4'h0, 4'hF, 4'hF, 64'd0,   64'd1,  2'd1, 1'b1};
    vecs[7]  = '{80'h10,               4'h1, 4'h0, 4'hF, 4'hF, 64'd0,   64'd1,  2'd0, 1'b1};
    vecs[8]  = '{80'h00887766554433221180, 4'h8, 4'h0, 4'hF, 4'hF, 64'h8877665544332211, 64'd9, 2'd0, 1'b1};
    vecs[9]  = '{80'h010073,           4'h7, 4'h3, 4'hF, 4'hF, 64'h100, 64'd9,  2'd0, 1'b1};
    vecs[10] = '{80'h081540,           4'h4, 4'h0, 4'h1, 4'h5, 64'd8,   64'd10, 2'd0, 1'b1};
    vecs[11] = '{80'h90,               4'h9, 4'h0, 4'hF, 4'hF, 64'd0,   64'd1,  2'd0, 1'b1};
    vecs[12] = '{80'hAB21,             4'h2, 4'h1, 4'hA, 4'hB, 64'd0,   64'd2,  2'd0, 1'b1};
    vecs[13] = '{80'h8FB0,             4'hB, 4'h0, 4'h8, 4'hF, 64'd0,   64'd2,  2'd0, 1'b1};
    vecs[14] = '{80'h64,               4'h6, 4'h4, 4'h0, 4'h0, 64'd0,   64'd0,  2'd3, 1'b0};

    // Power-up reset: memory is undefined, so only the state registers are checked.
    #12 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_pc", pc, 64'd0);
    chk("reset_count", 64'(instr_count), 64'd0);
    chk("reset_valid", 64'(instr_valid), 64'd1);

    for (int i = 0; i < 15; i++) begin
      logic [79:0] bv;
      bv = vecs[i].bytes;
      for (int k = 0; k < 10; k++) wr(64'(k), bv[8*k +: 8]);
      chk($sformatf("v%0d_icode", i), 64'(icode), 64'(vecs[i].icode));
      chk($sformatf("v%0d_stat", i), 64'(stat), 64'(vecs[i].stat));
      if (vecs[i].full) begin
        chk($sformatf("v%0d_ifun", i), 64'(ifun), 64'(vecs[i].ifun));
        chk($sformatf("v%0d_rA", i), 64'(rA), 64'(vecs[i].ra));
        chk($sformatf("v%0d_rB", i), 64'(rB), 64'(vecs[i].rb));
        chk($sformatf("v%0d_valC", i), valC, vecs[i].valc);
        chk($sformatf("v%0d_valP", i), valP, vecs[i].valp);
      end
    end
    chk("table_no_commit_count", 64'(instr_count), 64'd0);

    // Commit irmovq, then halt at pc 10.
    do_reset();
    begin
      logic [79:0] prog;
      prog = 80'h0AF430;
      for (int k = 0; k < 10; k++) wr(64'(k), prog[8*k +: 8]);
    end
    wr(64'd10, 8'h60);
    wr(64'd11, 8'h23);
    chk("irmov_valP", valP, 64'd10);
    commit(valP);
    chk("c1_pc", pc, 64'd10);
    chk("c1_icode", 64'(icode), 64'd6);
    chk("c1_rA", 64'(rA), 64'd2);
    chk("c1_rB", 64'(rB), 64'd3);
    chk("c1_valC", valC, 64'd0);
    chk("c1_valP", valP, 64'd12);
    chk("c1_count", 64'(instr_count), 64'd1);
    wr(64'd10, 8'h00);
    chk("hlt_pre_stat", 64'(stat), 64'd1);
    chk("hlt_pre_valid", 64'(instr_valid), 64'd1);
    commit(64'd11);
    chk("hlt_stat", 64'(stat), 64'd1);
    chk("hlt_valid", 64'(instr_valid), 64'd0);
    chk("hlt_pc", pc, 64'd10);
    chk("hlt_count", 64'(instr_count), 64'd2);
    commit(64'd0);
    chk("hlt_frozen_pc", pc, 64'd10);
    chk("hlt_frozen_count", 64'(instr_count), 64'd2);
    wr(64'd10, 8'h10);
    chk("hlt_latched_stat", 64'(stat), 64'd1);
    chk("hlt_icode_live", 64'(icode), 64'd1);

    // Asynchronous reset while halted, sampled between edges.
    #1 rst = 1'b1;
    #2;
    chk("arst_pc", pc, 64'd0);
    chk("arst_stat", 64'(stat), 64'd0);
    chk("arst_count", 64'(instr_count), 64'd0);
    chk("arst_valid", 64'(instr_valid), 64'd1);
    chk("arst_mem_kept", 64'(icode), 64'd3);
    rst = 1'b0;

    // Memory write and commit on the same edge: commit sees the old byte.
    @(negedge clk);
    imem_we = 1'b1; imem_waddr = 64'd0; imem_wdata = 8'h00;
    pc_we = 1'b1; pc_next = 64'd0;
    @(posedge clk); #1;
    imem_we = 1'b0; pc_we = 1'b0;
    chk("same_cyc_count", 64'(instr_count), 64'd1);
    chk("same_cyc_valid", 64'(instr_valid), 64'd1);
    chk("same_cyc_new_stat", 64'(stat), 64'd1);
    wr(64'd0, 8'h30);

    // Address limits of a 10-byte instruction.
    wr(64'd1014, 8'h30);
    wr(64'd1015, 8'h30);
    wr(64'd1016, 8'h00);
    do_reset();
    commit(64'd1014);
    chk("edge_ok_stat", 64'(stat), 64'd0);
    chk("edge_ok_valP", valP, 64'd1024);
    do_reset();
    commit(64'd1015);
    chk("edge_adr_stat", 64'(stat), 64'd2);
    chk("edge_adr_valP", valP, 64'd1016);
    chk("edge_adr_rA", 64'(rA), 64'hF);

    wr(64'd1020, 8'h70);
    do_reset();
    commit(64'd1020);
    chk("jxx_adr_stat", 64'(stat), 64'd2);

    // Out-of-range pc reads as 0 but ADR outranks HLT.
    do_reset();
    commit(64'd1024);
    chk("oor_pc", pc, 64'd1024);
    chk("oor_stat", 64'(stat), 64'd2);
    chk("oor_icode", 64'(icode), 64'd0);
    chk("oor_valP", valP, 64'd1025);
    chk("oor_count", 64'(instr_count), 64'd1);
    commit(64'd0);
    chk("oor_halt_pc", pc, 64'd1024);
    chk("oor_halt_stat", 64'(stat), 64'd2);
    chk("oor_halt_count", 64'(instr_count), 64'd2);
    chk("oor_halt_valid", 64'(instr_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
